// File: rtl/ra_pq_param.sv
// Register-array priority queue with min/max ordering,
// reject or evict-worst overflow policy, occupancy and error pulses.
module ra_pq_param #(
    parameter int KEY_WIDTH = 4,
    parameter int VAL_WIDTH = 4,
    parameter int DEPTH     = 4,
    parameter int MIN_FIRST = 1,
    parameter int EVICT     = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enq,
    input  logic                           deq,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0] kvi,
    output logic [KEY_WIDTH+VAL_WIDTH-1:0] kvo,
    output logic                           ovalid,
    output logic                           empty,
    output logic                           full,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           ovf,
    output logic                           udf
);

    localparam int W  = KEY_WIDTH + VAL_WIDTH;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]     kv_q  [DEPTH];
    logic [W-1:0]     kv_d  [DEPTH];
    logic [W-1:0]     up    [DEPTH];
    logic [W-1:0]     dn    [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [DEPTH-1:0] upv;
    logic [DEPTH-1:0] dnv;
    logic [DEPTH-1:0] gp;
    logic [DEPTH:0]   ge;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [W-1:0]     kvo_d;
    logic             empty_w;
    logic             full_w;
    logic             tail_bt;
    logic             ins;
    logic             repl;
    logic             pop;

    function automatic logic better(
        input logic [KEY_WIDTH-1:0] a,
        input logic [KEY_WIDTH-1:0] b
    );
        if (MIN_FIRST != 0) return a < b;
        else                return a > b;
    endfunction

    assign empty_w = (cnt_q == '0);
    assign full_w  = (cnt_q == CW'(DEPTH));
    assign tail_bt = better(kvi[W-1 -: KEY_WIDTH],
                            kv_q[DEPTH-1][W-1 -: KEY_WIDTH]);

    assign repl = enq && deq && !empty_w;
    assign pop  = deq && !enq && !empty_w;
    assign ins  = enq && (deq ? empty_w
                              : (!full_w || (EVICT != 0 && tail_bt)));

    // Per-slot compare of kvi (ge: kvi goes after this slot) and neighbour taps.
    always_comb begin
        ge     = '0;
        gp     = '0;
        up[0]  = kvi;
        upv[0] = 1'b1;
        gp[0]  = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            ge[i] = vld_q[i] &&
                    !better(kvi[W-1 -: KEY_WIDTH], kv_q[i][W-1 -: KEY_WIDTH]);
        end
        for (int i = 1; i < DEPTH; i++) begin
            gp[i]  = ge[i-1];
            up[i]  = kv_q[i-1];
            upv[i] = vld_q[i-1];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            dn[i]  = kv_q[i+1];
            dnv[i] = vld_q[i+1];
        end
        dn[DEPTH-1]  = '0;
        dnv[DEPTH-1] = 1'b0;
    end

    // Next slot contents: hold, shift up, shift down, or load kvi.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            kv_d[i]  = kv_q[i];
            vld_d[i] = vld_q[i];
            unique case (1'b1)
                pop: begin
                    kv_d[i]  = dn[i];
                    vld_d[i] = dnv[i];
                end
                repl: begin
                    if (ge[i+1]) begin
                        kv_d[i]  = dn[i];
                        vld_d[i] = dnv[i];
                    end else if (i == 0 || ge[i]) begin
                        kv_d[i]  = kvi;
                        vld_d[i] = 1'b1;
                    end
                end
                ins: begin
                    if (!ge[i]) begin
                        if (gp[i]) begin
                            kv_d[i]  = kvi;
                            vld_d[i] = 1'b1;
                        end else begin
                            kv_d[i]  = up[i];
                            vld_d[i] = upv[i];
                        end
                    end
                end
                default: ;
            endcase
        end
        cnt_d = cnt_q;
        if (pop)
            cnt_d = cnt_q - CW'(1);
        else if (ins && !full_w)
            cnt_d = cnt_q + CW'(1);
        kvo_d = vld_d[0] ? kv_d[0] : '0;
    end

    // State, registered head and one-cycle error pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) kv_q[i] <= '0;
            vld_q <= '0;
            cnt_q <= '0;
            kvo   <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) kv_q[i] <= kv_d[i];
            vld_q <= vld_d;
            cnt_q <= cnt_d;
            kvo   <= kvo_d;
            ovf   <= enq && !deq && full_w;
            udf   <= deq && empty_w;
        end
    end

    assign count  = cnt_q;
    assign empty  = empty_w;
    assign full   = full_w;
    assign ovalid = !empty_w;

endmodule

// File: tb/tb_ra_pq_param.sv
// Bench for ra_pq_param: three configurations share one stimulus
// stream; a reference model feeds a scoreboard checked each cycle.
module tb_ra_pq_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       enq;
    logic       deq;
    logic [7:0] kvi;

    logic [7:0] kvo_o  [3];
    logic       ovl_o  [3];
    logic       emp_o  [3];
    logic       ful_o  [3];
    logic [2:0] cnt_o  [3];
    logic       ovf_o  [3];
    logic       udf_o  [3];

    int tot = 0;
    int bad = 0;

    typedef struct {
        logic [7:0] kvo;
        int         cnt;
        bit         ovf;
        bit         udf;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] mk [3][4];
    int         mc [3];

    always #5 clk = ~clk;

    ra_pq_param u0 (
        .clk(clk), .rst(rst), .enq(enq), .deq(deq), .kvi(kvi),
        .kvo(kvo_o[0]), .ovalid(ovl_o[0]), .empty(emp_o[0]),
        .full(ful_o[0]), .count(cnt_o[0]), .ovf(ovf_o[0]), .udf(udf_o[0])
    );

    ra_pq_param #(.EVICT(1)) u1 (
        .clk(clk), .rst(rst), .enq(enq), .deq(deq), .kvi(kvi),
        .kvo(kvo_o[1]), .ovalid(ovl_o[1]), .empty(emp_o[1]),
        .full(ful_o[1]), .count(cnt_o[1]), .ovf(ovf_o[1]), .udf(udf_o[1])
    );

    ra_pq_param #(.MIN_FIRST(0)) u2 (
        .clk(clk), .rst(rst), .enq(enq), .deq(deq), .kvi(kvi),
        .kvo(kvo_o[2]), .ovalid(ovl_o[2]), .empty(emp_o[2]),
        .full(ful_o[2]), .count(cnt_o[2]), .ovf(ovf_o[2]), .udf(udf_o[2])
    );

    task automatic chk(input string tag, input int got, input int exp);
        tot++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // u2 orders largest-first; u0/u1 smallest-first
    function automatic bit mbetter(input int m, input logic [7:0] a,
                                   input logic [7:0] b);
        if (m == 2) return a[7:4] > b[7:4];
        else        return a[7:4] < b[7:4];
    endfunction

    task automatic m_ins(input int m, input logic [7:0] v);
        int  p;
        bit  fnd;
        p   = mc[m];
        fnd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!fnd && i < mc[m] && mbetter(m, v, mk[m][i])) begin
                p   = i;
                fnd = 1'b1;
            end
        end
        for (int i = 3; i > 0; i--) begin
            if (i > p) mk[m][i] = mk[m][i-1];
        end
        mk[m][p] = v;
        mc[m]++;
    endtask

    task automatic m_pop(input int m);
        for (int i = 0; i < 3; i++) mk[m][i] = mk[m][i+1];
        mc[m]--;
    endtask

    task automatic m_step(input int m, input bit e, input bit d,
                          input logic [7:0] v, output bit o, output bit u);
        o = 1'b0;
        u = 1'b0;
        if (d && mc[m] == 0) begin
            u = 1'b1;
            if (e) m_ins(m, v);
        end else if (d) begin
            m_pop(m);
            if (e) m_ins(m, v);
        end else if (e) begin
            if (mc[m] < 4) begin
                m_ins(m, v);
            end else begin
                o = 1'b1;
                if (m == 1 && mbetter(m, v, mk[m][3])) begin
                    mc[m] = 3;
                    m_ins(m, v);
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit e, input bit d,
                        input logic [7:0] v);
        exp_t x;
        bit   o;
        bit   u;
        @(negedge clk);
        rst = r;
        enq = e;
        deq = d;
        kvi = v;
        for (int m = 0; m < 3; m++) begin
            if (!r) begin
                mc[m] = 0;
                o = 1'b0;
                u = 1'b0;
            end else begin
                m_step(m, e, d, v, o, u);
            end
            x.kvo = (mc[m] != 0) ? mk[m][0] : 8'h00;
            x.cnt = mc[m];
            x.ovf = o;
            x.udf = u;
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < 3; m++) begin
            x = sb.pop_front();
            chk($sformatf("u%0d kvo", m), int'(kvo_o[m]), int'(x.kvo));
            chk($sformatf("u%0d count", m), int'(cnt_o[m]), x.cnt);
            chk($sformatf("u%0d empty", m), int'(emp_o[m]), int'(x.cnt == 0));
            chk($sformatf("u%0d full", m), int'(ful_o[m]), int'(x.cnt == 4));
            chk($sformatf("u%0d ovalid", m), int'(ovl_o[m]), int'(x.cnt != 0));
            chk($sformatf("u%0d ovf", m), int'(ovf_o[m]), int'(x.ovf));
            chk($sformatf("u%0d udf", m), int'(udf_o[m]), int'(x.udf));
        end
    endtask

    task automatic kv(input bit e, input bit d, input int k, input int vv);
        logic [3:0] kk;
        logic [3:0] va;
        kk = 4'(k);
        va = 4'(vv);
        step(1'b1, e, d, {kk, va});
    endtask

    task automatic rst_pulse();
        step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        rst = 1'b0;
        enq = 1'b0;
        deq = 1'b0;
        kvi = 8'h00;
        for (int m = 0; m < 3; m++) mc[m] = 0;
        // reset, and reset dominating enq/deq
        rst_pulse();
        step(1'b0, 1'b1, 1'b1, 8'h55);
        // basic fill and drain
        kv(1, 0, 8, 14); kv(1, 0, 11, 11); kv(1, 0, 9, 9); kv(1, 0, 10, 10);
        repeat (5) kv(0, 1, 0, 0);
        // mixed enq+deq
        rst_pulse();
        kv(1, 0, 15, 15); kv(1, 0, 1, 11); kv(1, 0, 10, 10);
        kv(1, 1, 12, 12);
        repeat (3) kv(0, 1, 0, 0);
        // ties stay FIFO
        rst_pulse();
        kv(1, 0, 9, 10); kv(1, 0, 9, 11); kv(1, 0, 9, 12);
        repeat (3) kv(0, 1, 0, 0);
        // full: reject vs evict, then replace while full
        rst_pulse();
        kv(1, 0, 3, 3); kv(1, 0, 5, 5); kv(1, 0, 7, 7); kv(1, 0, 9, 9);
        kv(1, 0, 2, 2); kv(0, 0, 0, 0);
        kv(1, 1, 2, 2);
        rst_pulse();
        kv(1, 0, 3, 3); kv(1, 0, 5, 5); kv(1, 0, 7, 7); kv(1, 0, 9, 9);
        kv(1, 0, 4, 4); kv(1, 0, 12, 0); kv(1, 0, 1, 1);
        repeat (4) kv(0, 1, 0, 0);
        // underflow
        kv(0, 1, 0, 0); kv(0, 0, 0, 0);
        kv(1, 1, 6, 6);
        kv(0, 1, 0, 0);
        // max-first ordering and mid-operation reset
        rst_pulse();
        kv(1, 0, 2, 1); kv(1, 0, 14, 2); kv(1, 0, 7, 3);
        rst_pulse();
        kv(1, 0, 2, 1); kv(1, 0, 14, 2); kv(1, 0, 7, 3);
        repeat (3) kv(0, 1, 0, 0);
        // random traffic
        for (int n = 0; n < 300; n++) begin
            step($urandom_range(0, 39) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 2) == 0, 8'($urandom_range(0, 255)));
        end
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
